// File: rtl/mips_pc_pkg.sv
// rtl/mips_pc_pkg.sv - shared types and constants for the program counter stage
// Contents:
//   pc_state_e           RUN/HALT controller states
//   pc_sel_e             next-PC source encoding
//   PC_INCR              sequential PC increment
//   DEFAULT_RESET_VECTOR PC value loaded on reset unless overridden
package mips_pc_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } pc_state_e;

    typedef enum logic [1:0] {
        SEL_SEQ    = 2'd0,
        SEL_BRANCH = 2'd1,
        SEL_JUMP   = 2'd2,
        SEL_JR     = 2'd3
    } pc_sel_e;

    localparam logic [31:0] PC_INCR              = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/program_counter_unit_if.sv
// rtl/program_counter_unit_if.sv - control/status bundle of the program counter stage
// Signals (slave = program counter, master = upstream decode/execute):
//   stall, branch, branchOffset, jump, jumpIndex, jumpReg, regTarget, haltReq  -> into PC stage
//   pc, pcPlus4, branchTarget, halted, misaligned, instrCount                   <- from PC stage
// Parameter COUNT_W sets the width of instrCount.
interface program_counter_unit_if #(
    parameter int COUNT_W = 32
);
    logic               stall;
    logic               branch;
    logic [31:0]        branchOffset;
    logic               jump;
    logic [25:0]        jumpIndex;
    logic               jumpReg;
    logic [31:0]        regTarget;
    logic               haltReq;
    logic [31:0]        pc;
    logic [31:0]        pcPlus4;
    logic [31:0]        branchTarget;
    logic               halted;
    logic               misaligned;
    logic [COUNT_W-1:0] instrCount;

    modport master (
        output stall, branch, branchOffset, jump, jumpIndex, jumpReg, regTarget, haltReq,
        input  pc, pcPlus4, branchTarget, halted, misaligned, instrCount
    );

    modport slave (
        input  stall, branch, branchOffset, jump, jumpIndex, jumpReg, regTarget, haltReq,
        output pc, pcPlus4, branchTarget, halted, misaligned, instrCount
    );

endinterface

// File: rtl/next_pc_mux.sv
// rtl/next_pc_mux.sv - combinational next-PC source selection
// Ports:
//   pc_plus4_i       sequential successor of the current PC
//   branch_target_i  pc_plus4 + branch offset
//   reg_target_i     rs value for JR
//   jump_index_i     instruction bits [25:0] for J/JAL
//   branch_i, jump_i, jump_reg_i  taken indications
//   next_pc_o        selected next PC (not yet alignment-handled)
module next_pc_mux
    import mips_pc_pkg::*;
(
    input  logic [31:0] pc_plus4_i,
    input  logic [31:0] branch_target_i,
    input  logic [31:0] reg_target_i,
    input  logic [25:0] jump_index_i,
    input  logic        branch_i,
    input  logic        jump_i,
    input  logic        jump_reg_i,
    output logic [31:0] next_pc_o
);

    pc_sel_e     sel;
    logic [31:0] jump_target;

    // Jumps stay inside the 256 MB region of the delay-slot address.
    assign jump_target = {pc_plus4_i[31:28], jump_index_i, 2'b00};

    always_comb begin
        sel = SEL_SEQ;
        if (jump_reg_i) begin
            sel = SEL_JR;
        end else if (jump_i) begin
            sel = SEL_JUMP;
        end else if (branch_i) begin
            sel = SEL_BRANCH;
        end
    end

    always_comb begin
        next_pc_o = pc_plus4_i;
        case (sel)
            SEL_JR:     next_pc_o = reg_target_i;
            SEL_JUMP:   next_pc_o = jump_target;
            SEL_BRANCH: next_pc_o = branch_target_i;
            default:    next_pc_o = pc_plus4_i;
        endcase
    end

endmodule

// File: rtl/program_counter_unit.sv
// rtl/program_counter_unit.sv - PC register, retired-instruction counter and RUN/HALT control
// Ports:
//   clk     rising-edge clock
//   reset   synchronous active-high reset
//   pc_bus  slave side of program_counter_unit_if (inputs: stall/branch/jump/jumpReg/haltReq
//           and targets; outputs: pc, pcPlus4, branchTarget, halted, misaligned, instrCount)
// Build option: PC_ALIGN_CHECK_EN - when defined, a misaligned selected target halts the
//   controller and sets the sticky misaligned flag; otherwise bits [1:0] are forced to zero.
module program_counter_unit
    import mips_pc_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter int          COUNT_W      = 32
) (
    input logic                    clk,
    input logic                    reset,
    program_counter_unit_if.slave  pc_bus
);

    pc_state_e          state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [31:0]        pc_plus4;
    logic [31:0]        branch_target;
    logic [31:0]        next_pc;
    logic               try_advance;
    logic               misalign_hit;
    logic               advance;

    assign pc_plus4      = pc_q + PC_INCR;
    assign branch_target = pc_plus4 + pc_bus.branchOffset;

    next_pc_mux u_next_pc_mux (
        .pc_plus4_i      (pc_plus4),
        .branch_target_i (branch_target),
        .reg_target_i    (pc_bus.regTarget),
        .jump_index_i    (pc_bus.jumpIndex),
        .branch_i        (pc_bus.branch),
        .jump_i          (pc_bus.jump),
        .jump_reg_i      (pc_bus.jumpReg),
        .next_pc_o       (next_pc)
    );

    // A halt request wins over any taken control transfer, stalled or not.
    assign try_advance = (state_q == RUN) && !pc_bus.stall && !pc_bus.haltReq;

`ifdef PC_ALIGN_CHECK_EN
    logic misaligned_q, misaligned_d;
    logic [31:0] next_pc_final;

    assign misalign_hit  = try_advance && (next_pc[1:0] != 2'b00);
    assign next_pc_final = next_pc;
    assign misaligned_d  = misaligned_q | misalign_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= misaligned_d;
        end
    end

    assign pc_bus.misaligned = misaligned_q;
`else
    logic [31:0] next_pc_final;

    assign misalign_hit      = 1'b0;
    assign next_pc_final     = next_pc & 32'hFFFF_FFFC;
    assign pc_bus.misaligned = 1'b0;
`endif

    assign advance = try_advance && !misalign_hit;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        case (state_q)
            RUN: begin
                if (pc_bus.haltReq || misalign_hit) begin
                    state_d = HALT;
                end
                if (advance) begin
                    pc_d    = next_pc_final;
                    count_d = count_q + COUNT_W'(1);
                end
            end
            default: begin
                state_d = HALT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= RESET_VECTOR;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    assign pc_bus.pc           = pc_q;
    assign pc_bus.pcPlus4      = pc_plus4;
    assign pc_bus.branchTarget = branch_target;
    assign pc_bus.halted       = (state_q == HALT);
    assign pc_bus.instrCount   = count_q;

endmodule

// File: tb/tb_program_counter_unit.sv
// tb/tb_program_counter_unit.sv - directed self-checking bench for program_counter_unit
module tb_program_counter_unit;

    logic clk = 1'b0;
    logic reset;
    int   compared = 0;
    int   mismatched = 0;

    program_counter_unit_if #(.COUNT_W(32)) bus ();

    program_counter_unit #(
        .RESET_VECTOR (32'h0000_0000),
        .COUNT_W      (32)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .pc_bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.stall        = 1'b0;
        bus.branch       = 1'b0;
        bus.branchOffset = 32'h0;
        bus.jump         = 1'b0;
        bus.jumpIndex    = 26'h0;
        bus.jumpReg      = 1'b0;
        bus.regTarget    = 32'h0;
        bus.haltReq      = 1'b0;
    endtask

    task automatic load_pc(input logic [31:0] target);
        bus.jumpReg   = 1'b1;
        bus.regTarget = target;
        step();
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        step();
        chk("rst_pc",        bus.pc,                  32'h0);
        chk("rst_halted",    {31'b0, bus.halted},     32'h0);
        chk("rst_misalign",  {31'b0, bus.misaligned}, 32'h0);
        chk("rst_count",     bus.instrCount,          32'h0);
        chk("rst_pcplus4",   bus.pcPlus4,             32'h4);
        reset = 1'b0;

        step(); chk("seq_pc1", bus.pc, 32'h4);
        step(); chk("seq_pc2", bus.pc, 32'h8);
        step(); chk("seq_pc3", bus.pc, 32'hC);
        chk("seq_count", bus.instrCount, 32'd3);

        // Backward branch: 0x10 + 4 - 16 = 0x4
        load_pc(32'h0000_0010);
        chk("jr_pc10", bus.pc, 32'h10);
        bus.branch       = 1'b1;
        bus.branchOffset = 32'hFFFF_FFF0;
        #1;
        chk("br_target", bus.branchTarget, 32'h0000_0004);
        step(); idle();
        chk("br_pc",    bus.pc,         32'h0000_0004);
        chk("br_count", bus.instrCount, 32'd5);

        // Jump beats branch; region bits come from pc+4
        load_pc(32'h1000_0000);
        bus.jump         = 1'b1;
        bus.branch       = 1'b1;
        bus.branchOffset = 32'h0000_0040;
        bus.jumpIndex    = 26'h0000040;
        step(); idle();
        chk("jmp_pc",    bus.pc,         32'h1000_0100);
        chk("jmp_count", bus.instrCount, 32'd7);

        // Stall freezes pc and counter
        load_pc(32'h0000_0020);
        bus.stall = 1'b1;
        step(); chk("stall1_pc", bus.pc, 32'h20); chk("stall1_cnt", bus.instrCount, 32'd8);
        step(); chk("stall2_pc", bus.pc, 32'h20); chk("stall2_cnt", bus.instrCount, 32'd8);
        bus.stall = 1'b0;
        step();
        chk("unstall_pc",  bus.pc,         32'h24);
        chk("unstall_cnt", bus.instrCount, 32'd9);

        // Wraparound of pcPlus4 and pc
        load_pc(32'hFFFF_FFFC);
        chk("wrap_pcplus4", bus.pcPlus4, 32'h0);
        step();
        chk("wrap_pc",  bus.pc,         32'h0);
        chk("wrap_cnt", bus.instrCount, 32'd11);

        // Misaligned JR target
        load_pc(32'h0000_0042);
`ifdef PC_ALIGN_CHECK_EN
        chk("mis_pc",       bus.pc,                  32'h0);
        chk("mis_halted",   {31'b0, bus.halted},     32'h1);
        chk("mis_flag",     {31'b0, bus.misaligned}, 32'h1);
        chk("mis_cnt",      bus.instrCount,          32'd11);
`else
        chk("mis_pc",       bus.pc,                  32'h40);
        chk("mis_halted",   {31'b0, bus.halted},     32'h0);
        chk("mis_flag",     {31'b0, bus.misaligned}, 32'h0);
        chk("mis_cnt",      bus.instrCount,          32'd12);
`endif

        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst2_pc",      bus.pc,                  32'h0);
        chk("rst2_cnt",     bus.instrCount,          32'h0);
        chk("rst2_misflag", {31'b0, bus.misaligned}, 32'h0);
        step();
        chk("rst2_adv", bus.pc, 32'h4);

        // Halt request beats a taken jump, even under stall
        bus.haltReq   = 1'b1;
        bus.jump      = 1'b1;
        bus.stall     = 1'b1;
        bus.jumpIndex = 26'h0000100;
        step(); idle();
        chk("halt_pc",     bus.pc,              32'h4);
        chk("halt_flag",   {31'b0, bus.halted}, 32'h1);
        chk("halt_cnt",    bus.instrCount,      32'd1);
        bus.jumpReg   = 1'b1;
        bus.regTarget = 32'h0000_0100;
        step(); step(); idle();
        chk("halt_hold_pc",  bus.pc,              32'h4);
        chk("halt_hold_flg", {31'b0, bus.halted}, 32'h1);
        chk("halt_hold_cnt", bus.instrCount,      32'd1);

        // Reset leaves HALT
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("unhalt_pc",  bus.pc,              32'h0);
        chk("unhalt_flg", {31'b0, bus.halted}, 32'h0);
        step();
        chk("unhalt_adv", bus.pc, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
